// File: rtl/result_packer.sv
// rtl/result_packer.sv - packs 1-bit threshold pixels into bytes for the result RAM
module result_packer #(
  parameter int WIDTH_BITS  = 8,
  parameter int HEIGHT_BITS = 8
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              iStart,
  input  logic [WIDTH_BITS-1:0]             iCol,
  input  logic [HEIGHT_BITS-1:0]            iRow,
  input  logic                              iData,
  input  logic                              iWren,
  input  logic                              iLast,
  output logic                              oReady,
  output logic [WIDTH_BITS+HEIGHT_BITS-4:0] oWrAddr,
  output logic [7:0]                        oWrData,
  output logic                              oWren,
  output logic [WIDTH_BITS+HEIGHT_BITS:0]   oCount,
  output logic                              oFinished,
  output logic                              oError
);

  localparam int AW = WIDTH_BITS + HEIGHT_BITS - 3;
  localparam int CW = WIDTH_BITS + HEIGHT_BITS + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state;
  logic [7:0]    acc;
  logic [AW-1:0] accAddr;
  logic          pending;
  logic          flushLast;

  logic          accept;
  logic [AW-1:0] pixelAddr;
  logic [7:0]    bitMask;
  logic [7:0]    freshWord;
  logic [7:0]    mergedWord;
  logic          outOfOrder;
  logic          completes;

  assign oReady = (state == RUN);

  // Decode the incoming pixel: its word, its bit, and how it relates to the pending word
  always_comb begin
    accept     = 1'b0;
    pixelAddr  = '0;
    bitMask    = 8'd0;
    freshWord  = 8'd0;
    mergedWord = 8'd0;
    outOfOrder = 1'b0;
    completes  = 1'b0;
    accept     = iWren && (state == RUN);
    pixelAddr  = {iRow, iCol[WIDTH_BITS-1:3]};
    bitMask    = 8'd1 << iCol[2:0];
    freshWord  = iData ? bitMask : 8'd0;
    // A re-written bit takes the latest value, hence mask-then-or
    mergedWord = ((pending ? acc : 8'd0) & ~bitMask) | freshWord;
    outOfOrder = pending && (pixelAddr != accAddr);
    completes  = (iCol[2:0] == 3'd7) || iLast;
  end

  // Frame FSM, accumulator, registered write port and status counters
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= 8'd0;
      accAddr   <= '0;
      pending   <= 1'b0;
      flushLast <= 1'b0;
      oWren     <= 1'b0;
      oWrAddr   <= '0;
      oWrData   <= 8'd0;
      oCount    <= '0;
      oFinished <= 1'b0;
      oError    <= 1'b0;
    end else begin
      oWren <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (iStart) begin
            state     <= RUN;
            oCount    <= '0;
            oError    <= 1'b0;
            acc       <= 8'd0;
            pending   <= 1'b0;
            oFinished <= 1'b0;
          end else if (state == DONE) begin
            // Delayed by a cycle so it rises only after the final write has been seen
            oFinished <= 1'b1;
          end
        end
        RUN: begin
          if (accept) begin
            if (iData && (oCount != {CW{1'b1}})) begin
              oCount <= oCount + 1'b1;
            end
            if (outOfOrder) begin
              // Retire the stale partial word, start over with this pixel
              oError  <= 1'b1;
              oWren   <= 1'b1;
              oWrAddr <= accAddr;
              oWrData <= acc;
              acc     <= freshWord;
              accAddr <= pixelAddr;
              pending <= 1'b1;
              if (completes) begin
                state     <= FLUSH;
                flushLast <= iLast;
              end
            end else if (completes) begin
              oWren   <= 1'b1;
              oWrAddr <= pixelAddr;
              oWrData <= mergedWord;
              acc     <= 8'd0;
              pending <= 1'b0;
              if (iLast) begin
                state <= DONE;
              end
            end else begin
              acc     <= mergedWord;
              accAddr <= pixelAddr;
              pending <= 1'b1;
            end
          end
        end
        FLUSH: begin
          // Second write of an out-of-order pair: the new word already complete
          oWren   <= 1'b1;
          oWrAddr <= accAddr;
          oWrData <= acc;
          acc     <= 8'd0;
          pending <= 1'b0;
          state   <= flushLast ? DONE : RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_packer.sv
// tb/tb_result_packer.sv - scoreboard bench for result_packer
module tb_result_packer;

  logic        clock = 1'b0;
  logic        reset;
  logic        iStart;
  logic [7:0]  iCol;
  logic [7:0]  iRow;
  logic        iData;
  logic        iWren;
  logic        iLast;
  logic        oReady;
  logic [12:0] oWrAddr;
  logic [7:0]  oWrData;
  logic        oWren;
  logic [16:0] oCount;
  logic        oFinished;
  logic        oError;

  int checks   = 0;
  int failures = 0;
  int writeCount = 0;
  logic [20:0] expQ[$];

  always #5 clock = ~clock;

  result_packer #(.WIDTH_BITS(8), .HEIGHT_BITS(8)) dut (
    .clock(clock), .reset(reset), .iStart(iStart), .iCol(iCol), .iRow(iRow),
    .iData(iData), .iWren(iWren), .iLast(iLast), .oReady(oReady),
    .oWrAddr(oWrAddr), .oWrData(oWrData), .oWren(oWren), .oCount(oCount),
    .oFinished(oFinished), .oError(oError)
  );

  task automatic sendPixel(input int col, input int row, input logic data, input logic last);
    @(negedge clock);
    iWren = 1'b1;
    iCol  = col[7:0];
    iRow  = row[7:0];
    iData = data;
    iLast = last;
  endtask

  task automatic idle();
    @(negedge clock);
    iWren  = 1'b0;
    iLast  = 1'b0;
    iStart = 1'b0;
    reset  = 1'b0;
  endtask

  task automatic pushWrite(input logic [12:0] addr, input logic [7:0] data);
    expQ.push_back({addr, data});
  endtask

  task automatic doReset();
    @(negedge clock);
    reset = 1'b1; iWren = 1'b0; iStart = 1'b0; iLast = 1'b0;
    idle();
  endtask

  task automatic doStart();
    @(negedge clock);
    iStart = 1'b1;
    idle();
  endtask

  task automatic test_reset();
    doReset();
    checks++;
    if ({oReady, oWren, oWrAddr, oWrData, oCount, oFinished, oError} !== 43'd0) begin
      failures++;
      $display("FAIL reset_outputs actual=%h required=0",
               {oReady, oWren, oWrAddr, oWrData, oCount, oFinished, oError});
    end
  endtask

  task automatic test_basic();
    logic [7:0] pattern;
    pattern = 8'b10001101;
    doStart();
    checks++;
    if (oReady !== 1'b1) begin failures++; $display("FAIL basic_ready actual=%b required=1", oReady); end
    pushWrite(13'h000, 8'h8D);
    for (int c = 0; c < 8; c++) sendPixel(c, 0, pattern[c], 1'b0);
    idle();
    checks++;
    if (oWren !== 1'b1) begin failures++; $display("FAIL basic_wren actual=%b required=1", oWren); end
    checks++;
    if (oCount !== 17'd4) begin failures++; $display("FAIL basic_count actual=%0d required=4", oCount); end
    idle();
    checks++;
    if (oWren !== 1'b0) begin failures++; $display("FAIL basic_single_strobe actual=%b required=0", oWren); end
  endtask

  task automatic test_out_of_order();
    doReset();
    doStart();
    pushWrite(13'h060, 8'h07);
    pushWrite(13'h061, 8'h80);
    for (int c = 0; c < 3; c++) sendPixel(c, 3, 1'b1, 1'b0);
    sendPixel(15, 3, 1'b1, 1'b0);
    idle();
    checks++;
    if ({oWren, oReady, oError} !== 3'b101) begin
      failures++; $display("FAIL ooo_first_write wren_ready_error actual=%b required=101", {oWren, oReady, oError});
    end
    idle();
    checks++;
    if ({oWren, oReady} !== 2'b11) begin
      failures++; $display("FAIL ooo_second_write wren_ready actual=%b required=11", {oWren, oReady});
    end
  endtask

  task automatic test_last_partial();
    doReset();
    doStart();
    pushWrite(13'h000, 8'h1F);
    for (int c = 0; c < 5; c++) sendPixel(c, 0, 1'b1, c == 4);
    idle();
    checks++;
    if ({oWren, oReady, oFinished} !== 3'b100) begin
      failures++; $display("FAIL last_write wren_ready_fin actual=%b required=100", {oWren, oReady, oFinished});
    end
    idle();
    checks++;
    if (oFinished !== 1'b1) begin failures++; $display("FAIL last_finished actual=%b required=1", oFinished); end
    for (int c = 5; c < 8; c++) sendPixel(c, 0, 1'b1, 1'b0);
    idle();
    idle();
    checks++;
    if ({oCount, oWren, oFinished} !== {17'd5, 1'b0, 1'b1}) begin
      failures++; $display("FAIL done_ignores_wren count_wren_fin actual=%h required=%h",
                           {oCount, oWren, oFinished}, {17'd5, 1'b0, 1'b1});
    end
  endtask

  task automatic test_restart();
    doStart();
    checks++;
    if ({oFinished, oCount, oReady} !== {1'b0, 17'd0, 1'b1}) begin
      failures++; $display("FAIL restart fin_count_ready actual=%h required=%h",
                           {oFinished, oCount, oReady}, {1'b0, 17'd0, 1'b1});
    end
    pushWrite(13'h020, 8'hFF);
    for (int c = 0; c < 8; c++) sendPixel(c, 1, 1'b1, 1'b0);
    idle();
    checks++;
    if (oCount !== 17'd8) begin failures++; $display("FAIL restart_count actual=%0d required=8", oCount); end
  endtask

  task automatic test_midreset();
    doReset();
    doStart();
    for (int c = 0; c < 6; c++) sendPixel(c, 2, 1'b1, 1'b0);
    @(negedge clock);
    iWren = 1'b0; reset = 1'b1;
    idle();
    checks++;
    if ({oReady, oWren, oWrAddr, oWrData, oCount, oFinished, oError} !== 43'd0) begin
      failures++; $display("FAIL midreset_outputs actual=%h required=0",
                           {oReady, oWren, oWrAddr, oWrData, oCount, oFinished, oError});
    end
    sendPixel(6, 2, 1'b1, 1'b0);
    sendPixel(7, 2, 1'b1, 1'b0);
    idle();
    idle();
    checks++;
    if ({oCount, oReady} !== 18'd0) begin
      failures++; $display("FAIL midreset_ignores_wren count_ready actual=%h required=0", {oCount, oReady});
    end
  endtask

  task automatic test_full_frame();
    int startWrites;
    logic [12:0] addr;
    doReset();
    doStart();
    startWrites = writeCount;
    for (int r = 0; r < 256; r++) begin
      for (int c = 0; c < 256; c++) begin
        if ((c % 8) == 7) begin
          addr = {r[7:0], c[7:3]};
          pushWrite(addr, 8'h55);
        end
        sendPixel(c, r, (c % 2) == 0, (r == 255) && (c == 255));
      end
    end
    idle();
    checks++;
    if ({oWren, oFinished} !== 2'b10) begin
      failures++; $display("FAIL frame_last_write wren_fin actual=%b required=10", {oWren, oFinished});
    end
    idle();
    checks++;
    if (oFinished !== 1'b1) begin failures++; $display("FAIL frame_finished actual=%b required=1", oFinished); end
    checks++;
    if (oCount !== 17'd32768) begin failures++; $display("FAIL frame_count actual=%0d required=32768", oCount); end
    checks++;
    if (oError !== 1'b0) begin failures++; $display("FAIL frame_error actual=%b required=0", oError); end
    checks++;
    if (writeCount - startWrites !== 8192) begin
      failures++; $display("FAIL frame_writes actual=%0d required=8192", writeCount - startWrites);
    end
  endtask

  initial begin
    reset = 1'b1; iStart = 1'b0; iCol = '0; iRow = '0; iData = 1'b0; iWren = 1'b0; iLast = 1'b0;
    fork
      forever begin
        logic [20:0] exp;
        @(negedge clock);
        if (oWren === 1'b1) begin
          writeCount++;
          checks++;
          if (expQ.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write addr=%h data=%h required=no write", oWrAddr, oWrData);
          end else begin
            exp = expQ.pop_front();
            if ({oWrAddr, oWrData} !== exp) begin
              failures++;
              $display("FAIL write_contents actual=%h/%h required=%h/%h",
                       oWrAddr, oWrData, exp[20:8], exp[7:0]);
            end
          end
        end
      end
    join_none
    test_reset();
    test_basic();
    test_out_of_order();
    test_last_partial();
    test_restart();
    test_midreset();
    test_full_frame();
    repeat (4) idle();
    checks++;
    if (expQ.size() != 0) begin
      failures++; $display("FAIL missing_writes actual=%0d required=0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
